// File: rtl/pdl_pkg.sv
// Shared definitions for the PDL PUF evaluation controller:
// FSM state encoding, default parameter values and a constant-foldable
// ceil(log2) helper used for derived widths.
package pdl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_EVAL,
    S_RELAX,
    S_DONE
  } pdl_state_t;

  localparam int unsigned DEF_STAGES        = 64;
  localparam int unsigned DEF_SAMPLES       = 7;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_EVAL_CYCLES   = 4;
  localparam int unsigned DEF_RELAX_CYCLES  = 4;

  // Returns ceil(log2(v)); 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pdl_arb_sync.sv
// Two-flop synchroniser for the asynchronous arbiter output.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset (both flops clear to 0)
//   arb_in   - raw arbiter output, asynchronous to clk
//   arb_sync - synchronised arbiter value (pure flop output)
module pdl_arb_sync (
  input  logic clk,
  input  logic reset,
  input  logic arb_in,
  output logic arb_sync
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      arb_sync <= 1'b0;
    end else begin
      meta     <= arb_in;
      arb_sync <= meta;
    end
  end

endmodule

// File: rtl/pdl_puf_eval_ctrl.sv
// Evaluation controller for an N-stage programmable-delay-line PUF.
// Latches a challenge onto the chain select buses, launches the race
// SAMPLES times, samples the synchronised arbiter output at the end of each
// launch window and majority-votes the samples into one response bit.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   chal_valid/chal_ready    - challenge handshake (ready only in IDLE)
//   chal_top/chal_btm        - per-stage top/bottom select words
//   abort                    - synchronous cancel of a running evaluation
//   pdl_sel_top/pdl_sel_btm  - registered select buses to the chain
//   pdl_launch               - registered race launch
//   arb_in                   - raw arbiter output (asynchronous)
//   resp_valid               - one-cycle response strobe
//   resp_bit/resp_ones       - majority result and count of 1 samples
//   busy                     - high whenever not IDLE
module pdl_puf_eval_ctrl
  import pdl_pkg::*;
#(
  parameter  int unsigned STAGES        = DEF_STAGES,
  parameter  int unsigned SAMPLES       = DEF_SAMPLES,
  parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter  int unsigned EVAL_CYCLES   = DEF_EVAL_CYCLES,
  parameter  int unsigned RELAX_CYCLES  = DEF_RELAX_CYCLES,
  localparam int unsigned CW            = clog2(SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [STAGES-1:0] chal_top,
  input  logic [STAGES-1:0] chal_btm,
  input  logic              abort,
  output logic [STAGES-1:0] pdl_sel_top,
  output logic [STAGES-1:0] pdl_sel_btm,
  output logic              pdl_launch,
  input  logic              arb_in,
  output logic              resp_valid,
  output logic              resp_bit,
  output logic [CW-1:0]     resp_ones,
  output logic              busy
);

  if ((SAMPLES % 2) == 0 || SAMPLES < 1) begin : g_bad_samples
    $error("pdl_puf_eval_ctrl: SAMPLES must be odd and >= 1");
  end
  if (SETTLE_CYCLES < 1 || EVAL_CYCLES < 3 || RELAX_CYCLES < 1) begin : g_bad_timing
    $error("pdl_puf_eval_ctrl: SETTLE>=1, EVAL>=3, RELAX>=1 required");
  end

  localparam int unsigned TMAX_A = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int unsigned TMAX   = (TMAX_A > RELAX_CYCLES) ? TMAX_A : RELAX_CYCLES;
  localparam int unsigned TW     = clog2(TMAX + 1);

  pdl_state_t    state;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] ones;
  logic [CW-1:0] samp;
  logic          arb_sync;

  pdl_arb_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .arb_in   (arb_in),
    .arb_sync (arb_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      ones        <= '0;
      samp        <= '0;
      chal_ready  <= 1'b1;
      busy        <= 1'b0;
      pdl_sel_top <= '0;
      pdl_sel_btm <= '0;
      pdl_launch  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_bit    <= 1'b0;
      resp_ones   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (chal_valid) begin
            pdl_sel_top <= chal_top;
            pdl_sel_btm <= chal_btm;
            ones        <= '0;
            samp        <= '0;
            tcnt        <= TW'(SETTLE_CYCLES - 1);
            chal_ready  <= 1'b0;
            busy        <= 1'b1;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE, S_EVAL, S_RELAX: begin
          if (abort) begin
            pdl_launch <= 1'b0;
            chal_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (tcnt != '0) begin
            tcnt <= tcnt - TW'(1);
          end else if (state == S_EVAL) begin
            // Sample taken on the last launch-high cycle; EVAL_CYCLES >= 3
            // guarantees the synchroniser reflects this launch.
            ones       <= ones + CW'(arb_sync);
            samp       <= samp + CW'(1);
            pdl_launch <= 1'b0;
            tcnt       <= TW'(RELAX_CYCLES - 1);
            state      <= S_RELAX;
          end else if (state == S_SETTLE || samp < CW'(SAMPLES)) begin
            pdl_launch <= 1'b1;
            tcnt       <= TW'(EVAL_CYCLES - 1);
            state      <= S_EVAL;
          end else begin
            // Response registers load on entry so they are valid during DONE.
            resp_valid <= 1'b1;
            resp_bit   <= (ones > CW'(SAMPLES / 2));
            resp_ones  <= ones;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          chal_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          pdl_launch <= 1'b0;
          chal_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdl_puf_eval_ctrl.sv
// Directed self-checking bench for pdl_puf_eval_ctrl with default parameters.
module tb_pdl_puf_eval_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chal_valid = 1'b0;
  logic        chal_ready;
  logic [63:0] chal_top = '0;
  logic [63:0] chal_btm = '0;
  logic        abort = 1'b0;
  logic [63:0] pdl_sel_top;
  logic [63:0] pdl_sel_btm;
  logic        pdl_launch;
  logic        arb_in = 1'b0;
  logic        resp_valid;
  logic        resp_bit;
  logic [2:0]  resp_ones;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdl_puf_eval_ctrl #(
    .STAGES        (64),
    .SAMPLES       (7),
    .SETTLE_CYCLES (4),
    .EVAL_CYCLES   (4),
    .RELAX_CYCLES  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chal_valid  (chal_valid),
    .chal_ready  (chal_ready),
    .chal_top    (chal_top),
    .chal_btm    (chal_btm),
    .abort       (abort),
    .pdl_sel_top (pdl_sel_top),
    .pdl_sel_btm (pdl_sel_btm),
    .pdl_launch  (pdl_launch),
    .arb_in      (arb_in),
    .resp_valid  (resp_valid),
    .resp_bit    (resp_bit),
    .resp_ones   (resp_ones),
    .busy        (busy)
  );

  typedef struct {
    logic [63:0] top;
    logic [63:0] btm;
    logic [6:0]  pat;       // bit k = arb_in level during evaluation k+1
    logic [2:0]  exp_ones;
    logic        exp_bit;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers a challenge in cycle 0 (accepted at the closing edge), then runs
  // cycles 1..64 driving arb_in per evaluation window. Evaluation k occupies
  // cycles 5+8k..8+8k; the level is held until the next window starts.
  task automatic run_chal(input string tag, input logic [63:0] top, input logic [63:0] btm,
                          input logic [6:0] pat, input logic [2:0] eones, input logic ebit,
                          input int second_at);
    int nvalid;
    int vcycle;
    int k;
    logic [2:0] ones_at;
    logic bit_at;
    nvalid  = 0;
    vcycle  = -1;
    ones_at = '0;
    bit_at  = 1'b0;
    chal_top   = top;
    chal_btm   = btm;
    chal_valid = 1'b1;
    arb_in     = 1'b0;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      if (c >= 5) begin
        k = (c - 5) / 8;
        if (k > 6) k = 6;
        arb_in = pat[k];
      end
      if (c == second_at) begin
        chal_valid = 1'b1;
        chal_top   = ~top;
        chal_btm   = top;
      end else begin
        chal_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 1) begin
        chk({tag, " sel_top"}, pdl_sel_top, top);
        chk({tag, " sel_btm"}, pdl_sel_btm, btm);
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " ready_low"}, chal_ready, 1'b0);
      end
      if (resp_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          vcycle  = c;
          ones_at = resp_ones;
          bit_at  = resp_bit;
        end
      end
      if (c == 62) chk({tag, " ready_c62"}, chal_ready, 1'b1);
      @(posedge clk); #1;
    end
    chal_valid = 1'b0;
    chk({tag, " nvalid"}, 64'(nvalid), 64'd1);
    chk({tag, " valid_cycle"}, 64'(vcycle), 64'd61);
    chk({tag, " ones"}, ones_at, eones);
    chk({tag, " bit"}, bit_at, ebit);
    chk({tag, " ones_hold"}, resp_ones, eones);
    chk({tag, " sel_hold"}, pdl_sel_top, top);
  endtask

  initial begin
    int nvalid;

    vecs[0] = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 7'b1111111, 3'd7, 1'b1};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 7'b0000000, 3'd0, 1'b0};
    vecs[2] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 7'b0010101, 3'd3, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 7'b1010101, 3'd4, 1'b1};
    vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0001, 7'b1110000, 3'd3, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 7'b0111111, 3'd6, 1'b1};

    #2 reset = 1'b1;
    #1;
    chk("rst chal_ready", chal_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst launch", pdl_launch, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_ones", resp_ones, 3'd0);
    chk("rst sel_top", pdl_sel_top, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_chal($sformatf("vec%0d", i), vecs[i].top, vecs[i].btm, vecs[i].pat,
               vecs[i].exp_ones, vecs[i].exp_bit, -1);
    end

    // Abort during the 3rd evaluation (cycles 21..24).
    chal_top   = 64'h1357_9BDF_0246_8ACE;
    chal_btm   = 64'hECA8_6420_FDB9_7531;
    chal_valid = 1'b1;
    arb_in     = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    for (int c = 1; c < 22; c++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    chk("abort launch_before", pdl_launch, 1'b1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort launch_after", pdl_launch, 1'b0);
    chk("abort ready", chal_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    nvalid = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (resp_valid) nvalid++;
    end
    chk("abort no_valid", 64'(nvalid), 64'd0);
    chk("abort ones_kept", resp_ones, vecs[5].exp_ones);
    chk("abort bit_kept", resp_bit, vecs[5].exp_bit);
    chk("abort sel_kept", pdl_sel_top, 64'h1357_9BDF_0246_8ACE);
    arb_in = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the first RELAX (cycles 9..12).
    chal_top   = 64'h0F0F_0F0F_0F0F_0F0F;
    chal_btm   = 64'hF0F0_F0F0_F0F0_F0F0;
    chal_valid = 1'b1;
    arb_in     = 1'b1;
    @(posedge clk); #1;
    chal_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst ready", chal_ready, 1'b1);
    chk("mid_rst busy", busy, 1'b0);
    chk("mid_rst launch", pdl_launch, 1'b0);
    chk("mid_rst resp_ones", resp_ones, 3'd0);
    chk("mid_rst resp_bit", resp_bit, 1'b0);
    chk("mid_rst sel_top", pdl_sel_top, 64'd0);
    chk("mid_rst sel_btm", pdl_sel_btm, 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    arb_in = 1'b0;
    @(posedge clk); #1;
    run_chal("post_rst", 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
             7'b1010101, 3'd4, 1'b1, -1);

    // Second challenge offered while busy must be ignored.
    run_chal("busy_offer", 64'hC3C3_C3C3_3C3C_3C3C, 64'h3C3C_3C3C_C3C3_C3C3,
             7'b1111111, 3'd7, 1'b1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pdl_puf_eval_ctrl.md
Name: pdl_puf_eval_ctrl

Overview:
- Parametrised evaluation controller for an N-stage programmable-delay-line (PDL) PUF chain.
- Accepts a challenge as per-stage top and bottom select words and drives them to the chain's stage selects.
- Launches the race SAMPLES times and samples the external arbiter output through a synchroniser.
- Majority-votes the samples into one response bit, with a confidence count. Sits between the challenge host interface and the PDL switch chain plus arbiter.

Parameters:
- STAGES, 64, number of PDL switch stages; width of each select word.
- SAMPLES, 7, evaluations per challenge; must be odd and >=1. Elaboration error otherwise.
- SETTLE_CYCLES, 4, cycles the selects are stable before the first launch; >=1.
- EVAL_CYCLES, 4, cycles launch is held high per evaluation; >=3.
- RELAX_CYCLES, 4, cycles launch is held low between evaluations; >=1.
- CW, $clog2(SAMPLES+1), width of the ones counter. Derived; not overridable.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  high only in IDLE.
- chal_top  in  STAGES  select bits for the top blocks.
- chal_btm  in  STAGES  select bits for the bottom blocks.
- abort  in  1  synchronous cancel of the evaluation in progress.
- pdl_sel_top  out  STAGES  registered top select bus to the chain.
- pdl_sel_btm  out  STAGES  registered bottom select bus to the chain.
- pdl_launch  out  1  registered race launch to both chain inputs.
- arb_in  in  1  raw arbiter output; asynchronous to clk.
- resp_valid  out  1  one-cycle pulse: response ready.
- resp_bit  out  1  majority result.
- resp_ones  out  CW  count of samples equal to 1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: chal_ready=1, every other output 0. The FSM enters IDLE and the sync flops, counters and registers clear. Reset in any state aborts with no resp_valid.
- States and transitions:
  - IDLE: chal_valid&&chal_ready latches chal_top and chal_btm into pdl_sel_* at the accepting edge, clears the ones counter, and moves to SETTLE.
  - SETTLE: runs SETTLE_CYCLES cycles with launch=0, then goes to EVAL.
  - EVAL: runs EVAL_CYCLES cycles with launch=1.
    - arb_in passes through a 2-flop synchroniser.
    - On the last EVAL cycle, the synchronised value is added to the ones counter and the sample counter increments.
  - RELAX: runs RELAX_CYCLES cycles with launch=0. Goes to EVAL if the sample count < SAMPLES, else to DONE.
  - DONE: lasts one cycle.
    - resp_valid=1.
    - resp_bit = (ones > SAMPLES/2).
    - resp_ones = ones.
    - Next state is IDLE.
- Latency: with acceptance at cycle 0, resp_valid occurs at cycle SETTLE_CYCLES + SAMPLES*(EVAL_CYCLES+RELAX_CYCLES) + 1. Defaults give cycle 61. chal_ready rises the following cycle.
- Output hold rules:
  - resp_bit and resp_ones hold until the next DONE.
  - pdl_sel_* hold until the next acceptance. They are not cleared by DONE or abort.
- Flow control: chal_valid outside IDLE is ignored; there is no queueing.
- Abort: abort high in SETTLE, EVAL or RELAX forces IDLE on the next edge.
  - pdl_launch drops to 0 on that same edge.
  - No resp_valid is produced; resp_* are unchanged.
  - abort in IDLE or DONE has no effect.
- Counters saturate by construction and never wrap: the ones count is <= SAMPLES.
- pdl_launch is glitch-free (a flop output) and changes only on clk edges.

Decomposition:
- Shared package pdl_pkg holds:
  - the state encoding (IDLE, SETTLE, EVAL, RELAX, DONE);
  - default parameter constants;
  - a clog2 helper.
- Sub-module pdl_arb_sync holds the 2-flop synchroniser with async reset to 0 and no combinational path.
- The PDL chain itself stays outside this block.

Test Plan:
- Reset, then accept a challenge with top=64'hFFFF_0000_FFFF_0000 and btm=~top, arb_in=1 constant:
  - pdl_sel_* match the challenge one cycle after acceptance;
  - resp_valid occurs at cycle 61 with resp_bit=1 and resp_ones=7;
  - chal_ready is high at cycle 62.
- arb_in=0 constant: resp_bit=0, resp_ones=0.
- arb_in set to 1 during evaluations 1,3,5 only (0 otherwise) -> resp_ones=3, resp_bit=0. For 4 ones -> resp_bit=1.
- Second challenge offered while busy (cycle 20): it is ignored, pdl_sel_* are unchanged, and exactly one resp_valid occurs.
- abort pulsed in the 3rd EVAL:
  - pdl_launch=0 and state IDLE next cycle;
  - no resp_valid;
  - the previous resp_* are retained.
- reset asserted mid-RELAX: all outputs return to reset values immediately (asynchronously). A fresh challenge afterwards completes normally at cycle 61.
